// File: rtl/display_pkg.sv
// Shared display timing types and 640x480@60 constants.
// Used by the DVI raster generator and its sync delay line.
package display_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Logical (active-high) raster flags carried down the delay line.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_BLANK = '0;

endpackage

// File: rtl/dvi_sync_delay.sv
// Fixed-depth delay line for {de, hs, vs} flags.
// Resets to blank with syncs inactive.
module dvi_sync_delay
  import display_pkg::*;
#(
  parameter int LEAD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  logic [2:0] sr [LEAD];

  // Shift every cycle; stage LEAD-1 is the pin-aligned output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEAD; i++) begin
        sr[i] <= SYNC_BLANK;
      end
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LEAD; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LEAD-1];

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: pixel requests lead
// data enable and syncs by LEAD cycles.
module dvi_timing_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LEAD      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       pix_req,
  output logic [9:0] req_x,
  output logic [9:0] req_y,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] ctrl,
  output logic       frame_start,
  output logic       line_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("dvi_timing_gen: raster total exceeds 1024");
  end
  if (LEAD < 1 || LEAD > 8) begin : g_bad_lead
    $error("dvi_timing_gen: LEAD out of range 1..8");
  end

  state_t state, state_nxt;
  coord_t h_cnt, v_cnt;
  coord_t h_nxt, v_nxt;
  logic   h_last, v_last;
  logic   run_n, act_n, hs_n, vs_n;
  logic   hs_q, vs_q;
  sync_t  sd_in, sd_out;

  // Next state, next counters and the counter-domain flags.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    h_last    = (int'(h_cnt) == H_TOTAL - 1);
    v_last    = (int'(v_cnt) == V_TOTAL - 1);
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (h_last && v_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      if (h_last) begin
        h_nxt = '0;
        v_nxt = v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
    run_n = (state_nxt != IDLE);
    act_n = run_n
         && (int'(h_nxt) < H_ACTIVE)
         && (int'(v_nxt) < V_ACTIVE);
    hs_n  = run_n
         && (int'(h_nxt) >= HS_BEG)
         && (int'(h_nxt) < HS_END);
    vs_n  = run_n
         && (int'(v_nxt) >= VS_BEG)
         && (int'(v_nxt) < VS_END);
  end

  // State and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Request-side outputs, registered in step with the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      pix_req     <= act_n;
      frame_start <= act_n && (h_nxt == '0) && (v_nxt == '0);
      line_start  <= act_n && (h_nxt == '0);
      hs_q        <= hs_n;
      vs_q        <= vs_n;
    end
  end

  assign req_x   = h_cnt;
  assign req_y   = v_cnt;
  assign running = (state != IDLE);

  assign sd_in = '{de: pix_req, hs: hs_q, vs: vs_q};

  dvi_sync_delay #(
    .LEAD (LEAD)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (sd_in),
    .dout (sd_out)
  );

  assign de    = sd_out.de;
  assign hsync = (HSYNC_POL != 0) ? sd_out.hs : ~sd_out.hs;
  assign vsync = (VSYNC_POL != 0) ? sd_out.vs : ~sd_out.vs;
  assign ctrl  = {vsync, hsync};

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench for dvi_timing_gen on a reduced raster
// (15x8 total, 8x4 active) at LEAD=2 plus a LEAD=5 copy.
module tb_dvi_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int L2 = 2;
  localparam int L5 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pix_req, de, hsync, vsync;
  logic       frame_start, line_start, running;
  logic [9:0] req_x, req_y;
  logic [1:0] ctrl;

  logic       pix_req5, de5, hsync5, vsync5;
  logic       fs5, ls5, running5;
  logic [9:0] req_x5, req_y5;
  logic [1:0] ctrl5;

  always #5 clk = ~clk;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .LEAD(L2)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_req(pix_req), .req_x(req_x), .req_y(req_y),
    .de(de), .hsync(hsync), .vsync(vsync), .ctrl(ctrl),
    .frame_start(frame_start), .line_start(line_start),
    .running(running)
  );

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .LEAD(L5)
  ) u_dut5 (
    .clk(clk), .rst(rst), .enable(enable),
    .pix_req(pix_req5), .req_x(req_x5), .req_y(req_y5),
    .de(de5), .hsync(hsync5), .vsync(vsync5), .ctrl(ctrl5),
    .frame_start(fs5), .line_start(ls5),
    .running(running5)
  );

  typedef struct {
    int x;
    int y;
    bit fs;
    bit ls;
  } pix_t;

  pix_t sbq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;
  int stop_q = 1 << 30;
  bit sb_on  = 0;
  bit pin_on = 0;
  bit chk_de = 0;

  int last_fs  = 0;
  bit fs_valid = 0;
  int ls_cnt   = 0;
  int fs_seen  = 0;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_frame();
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        sbq.push_back('{x: x, y: y, fs: (x == 0 && y == 0),
                        ls: (x == 0)});
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expected pixel per pix_req.
  initial forever begin
    @(negedge clk);
    if (sb_on && pix_req) begin
      if (sbq.size() == 0) begin
        check(1'b0, "sb_underflow", int'(req_x), -1);
      end else begin
        pix_t e;
        int a, x;
        e = sbq.pop_front();
        a = int'(req_x) * 10000 + int'(req_y) * 100
          + int'(frame_start) * 10 + int'(line_start);
        x = e.x * 10000 + e.y * 100 + int'(e.fs) * 10 + int'(e.ls);
        check(a == x, "pixel", a, x);
      end
      if (frame_start) begin
        if (fs_valid) begin
          check(cyc - last_fs == FT, "frame_period",
                cyc - last_fs, FT);
          check(ls_cnt == VA, "lines_per_frame", ls_cnt, VA);
        end
        last_fs  = cyc;
        fs_valid = 1;
        ls_cnt   = 0;
        fs_seen++;
      end
      if (line_start) ls_cnt++;
    end
  end

  // Pin model: position derived from cycles since start.
  initial forever begin
    @(negedge clk);
    if (pin_on && !rst) begin
      int q, col, row, a, e;
      bit ea, ehs, evs;
      q   = cyc - t0 - L2;
      ea  = 0;
      ehs = 0;
      evs = 0;
      if (q >= 0 && q < stop_q) begin
        col = q % HT;
        row = (q / HT) % VT;
        ea  = (col < HA) && (row < VA);
        ehs = (col >= HA + HF) && (col < HA + HF + HS);
        evs = (row >= VA + VF) && (row < VA + VF + VS);
      end
      a = int'({de, hsync, vsync, ctrl});
      e = int'({ea, ~ehs, ~evs, ~evs, ~ehs});
      check(a == e, "pins", a, e);
    end
  end

  // de must equal pix_req delayed LEAD cycles in both builds.
  initial begin
    logic [7:0] h2, h5;
    h2 = '0;
    h5 = '0;
    forever begin
      @(negedge clk);
      if (chk_de) begin
        check(de == h2[L2-1], "de_lead2", int'(de), int'(h2[L2-1]));
        check(de5 == h5[L5-1], "de_lead5", int'(de5), int'(h5[L5-1]));
      end
      h2 = {h2[6:0], pix_req};
      h5 = {h5[6:0], pix_req5};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check(pix_req == 0 && frame_start == 0 && line_start == 0,
          "rst_req", int'({pix_req, frame_start, line_start}), 0);
    check(req_x == 0 && req_y == 0, "rst_xy",
          int'(req_x) + int'(req_y), 0);
    check(de == 0 && running == 0, "rst_de_run",
          int'({de, running}), 0);
    check(ctrl == 2'b11 && hsync && vsync, "rst_ctrl",
          int'(ctrl), 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int f = 0; f < 4; f++) push_frame();
    sb_on  = 1;
    chk_de = 1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    t0     = cyc;
    pin_on = 1;
    check(pix_req && frame_start && running, "start_req",
          int'({pix_req, frame_start, running}), 7);
    check(de == 0, "start_de_k0", int'(de), 0);
    for (k = 1; k <= L2; k++) begin
      @(posedge clk);
      #1;
      check(de == (k == L2), "start_de", int'(de), int'(k == L2));
    end

    while (cyc - t0 < 2 * FT + 20) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check(running == 1, "drain_running", int'(running), 1);
    enable = 1'b1;

    while (cyc - t0 < 3 * FT + 20) @(negedge clk);
    stop_q = 4 * FT;
    enable = 1'b0;
    while (cyc - t0 < 4 * FT - 1) @(negedge clk);
    check(running == 1, "stop_last_run", int'(running), 1);
    @(negedge clk);
    check(running == 0, "stop_idle", int'(running), 0);
    repeat (L2 + 3) @(negedge clk);
    check(req_x == 0 && req_y == 0 && pix_req == 0, "idle_hold",
          int'(req_x) + int'(req_y) + int'(pix_req), 0);
    check(de == 0 && ctrl == 2'b11, "idle_pins",
          int'({de, ctrl}), 3);
    check(sbq.size() == 0, "sb_drained", sbq.size(), 0);
    check(fs_seen == 4, "frames_seen", fs_seen, 4);
    check(ls_cnt == VA, "last_lines", ls_cnt, VA);

    sb_on  = 0;
    pin_on = 0;
    chk_de = 0;
    enable = 1'b1;
    k = 0;
    while (!(de && de5) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(de && de5, "resume_de", int'({de, de5}), 3);
    #1;
    rst = 1'b1;
    #1;
    check(de == 0 && de5 == 0 && pix_req == 0, "async_rst_de",
          int'({de, de5, pix_req}), 0);
    check(ctrl == 2'b11 && running == 0, "async_rst_ctrl",
          int'({ctrl, running}), 6);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
